// File: rtl/fft_frame_scheduler.sv
// Sequences one FFT pass per accepted audio window: latch, start, wait for done, publish on frame tick.
// Also handles window decimation, a compute watchdog and saturating drop/timeout statistics.
module fft_frame_scheduler #(
    parameter int SKIP    = 0,
    parameter int TIMEOUT = 1023,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             new_t,
    input  logic             fft_done,
    input  logic             frame_tick,
    output logic             latch_t,
    output logic             fft_start,
    output logic             publish,
    output logic             busy,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] overrun_cnt,
    output logic [CNT_W-1:0] timeout_cnt
);

    localparam int SKW = (SKIP > 0) ? $clog2(SKIP + 1) : 1;
    localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [SKW-1:0]   SKIP_LD = SKW'(SKIP);
    localparam logic [TW-1:0]    T_MAX   = TW'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LATCH   = 3'd1,
        S_START   = 3'd2,
        S_RUN     = 3'd3,
        S_WAIT    = 3'd4,
        S_PUBLISH = 3'd5
    } state_t;

    state_t         state;
    logic [SKW-1:0] skip_cnt;
    logic [TW-1:0]  timer;

    assign busy    = (state != S_IDLE);
    assign state_o = state;

    // Pulse outputs are registered together with the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            latch_t     <= 1'b0;
            fft_start   <= 1'b0;
            publish     <= 1'b0;
            skip_cnt    <= '0;
            timer       <= '0;
            overrun_cnt <= '0;
            timeout_cnt <= '0;
        end else begin
            latch_t   <= 1'b0;
            fft_start <= 1'b0;
            publish   <= 1'b0;

            if (new_t && state != S_IDLE && overrun_cnt != CNT_MAX)
                overrun_cnt <= overrun_cnt + 1'b1;

            case (state)
                S_IDLE: begin
                    if (new_t) begin
                        if (skip_cnt == '0) begin
                            state    <= S_LATCH;
                            latch_t  <= 1'b1;
                            skip_cnt <= SKIP_LD;
                        end else begin
                            skip_cnt <= skip_cnt - 1'b1;
                        end
                    end
                end
                S_LATCH: begin
                    state     <= S_START;
                    fft_start <= 1'b1;
                end
                S_START: begin
                    state <= S_RUN;
                    timer <= '0;
                end
                S_RUN: begin
                    // A done arriving on the last allowed cycle still completes the pass.
                    if (fft_done) begin
                        state <= S_WAIT;
                    end else if (timer == T_MAX) begin
                        state <= S_IDLE;
                        if (timeout_cnt != CNT_MAX)
                            timeout_cnt <= timeout_cnt + 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (frame_tick) begin
                        state   <= S_PUBLISH;
                        publish <= 1'b1;
                    end
                end
                S_PUBLISH: state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Two scheduler instances (no decimation / long watchdog, and SKIP=2 / short watchdog) share stimulus;
// a timestamp-based model of each window's life predicts every output on every cycle.
module tb_fft_frame_scheduler;

    logic clk = 1'b0;
    logic reset = 1'b0, new_t = 1'b0, fft_done = 1'b0, frame_tick = 1'b0;

    logic [2:0] st  [2];
    logic       lat [2], sta [2], pub [2], bsy [2];
    logic [7:0] ovc [2], toc [2];

    always #5 clk = ~clk;

    fft_frame_scheduler #(.SKIP(0), .TIMEOUT(40), .CNT_W(8)) dut0 (
        .clk(clk), .reset(reset), .new_t(new_t), .fft_done(fft_done), .frame_tick(frame_tick),
        .latch_t(lat[0]), .fft_start(sta[0]), .publish(pub[0]), .busy(bsy[0]),
        .state_o(st[0]), .overrun_cnt(ovc[0]), .timeout_cnt(toc[0]));

    fft_frame_scheduler #(.SKIP(2), .TIMEOUT(15), .CNT_W(8)) dut1 (
        .clk(clk), .reset(reset), .new_t(new_t), .fft_done(fft_done), .frame_tick(frame_tick),
        .latch_t(lat[1]), .fft_start(sta[1]), .publish(pub[1]), .busy(bsy[1]),
        .state_o(st[1]), .overrun_cnt(ovc[1]), .timeout_cnt(toc[1]));

    localparam int SKP [2] = '{0, 2};
    localparam int TMO [2] = '{40, 15};
    localparam int CMAX = 255;

    // Model: each window is described by its accept, done and tick cycles.
    bit act [2];
    int acc [2], dn [2], tk [2];
    int skp [2], m_ov [2], m_to [2];

    int  cyc = 0;
    bit  chk_en = 1'b0;
    int  errors = 0, checks = 0;
    int  lat_seen [2] = '{0, 0};
    int  pub_seen [2] = '{0, 0};

    function automatic int exp_state(input int i, input int c);
        if (!act[i]) return 0;
        if (c == acc[i] + 1) return 1;
        if (c == acc[i] + 2) return 2;
        if (dn[i] < 0) return (c <= acc[i] + 3 + TMO[i]) ? 3 : 0;
        if (c <= dn[i]) return 3;
        if (tk[i] < 0 || c <= tk[i]) return 4;
        if (c == tk[i] + 1) return 5;
        return 0;
    endfunction

    task automatic model_step(input int c, input logic r, nt, fd, ft);
        for (int i = 0; i < 2; i++) begin
            int s;
            s = exp_state(i, c);
            if (r) begin
                act[i] = 0; skp[i] = 0; m_ov[i] = 0; m_to[i] = 0;
            end else if (s == 0) begin
                act[i] = 0;
                if (nt) begin
                    if (skp[i] == 0) begin
                        act[i] = 1; acc[i] = c; dn[i] = -1; tk[i] = -1; skp[i] = SKP[i];
                    end else begin
                        skp[i] = skp[i] - 1;
                    end
                end
            end else begin
                if (nt && m_ov[i] < CMAX) m_ov[i] = m_ov[i] + 1;
                if (s == 3) begin
                    if (fd) dn[i] = c;
                    else if (c == acc[i] + 3 + TMO[i] && m_to[i] < CMAX) m_to[i] = m_to[i] + 1;
                end
                if (s == 4 && ft) tk[i] = c;
            end
        end
    endtask

    task automatic check(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, got, expv);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                int es;
                es = exp_state(i, cyc);
                check($sformatf("state%0d", i), int'(st[i]), es);
                check($sformatf("busy%0d", i), int'(bsy[i]), int'(es != 0));
                check($sformatf("latch%0d", i), int'(lat[i]), int'(es == 1));
                check($sformatf("start%0d", i), int'(sta[i]), int'(es == 2));
                check($sformatf("publish%0d", i), int'(pub[i]), int'(es == 5));
                check($sformatf("overrun%0d", i), int'(ovc[i]), m_ov[i]);
                check($sformatf("timeout%0d", i), int'(toc[i]), m_to[i]);
                lat_seen[i] += int'(lat[i]);
                pub_seen[i] += int'(pub[i]);
            end
        end
    end

    task automatic tick_cycle(input logic r, nt, fd, ft);
        reset = r; new_t = nt; fft_done = fd; frame_tick = ft;
        @(posedge clk);
        model_step(cyc, r, nt, fd, ft);
        cyc++;
        @(negedge clk);
        reset = 1'b0; new_t = 1'b0; fft_done = 1'b0; frame_tick = 1'b0;
    endtask

    task automatic do_reset();
        tick_cycle(1, 0, 0, 0);
        for (int j = 0; j < 3; j++) tick_cycle(0, 0, 0, 0);
    endtask

    initial begin
        int base, rel, l0, p0;
        tick_cycle(1, 0, 0, 0);
        chk_en = 1'b1;
        tick_cycle(1, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            check("rst_state", int'(st[i]), 0);
            check("rst_busy", int'(bsy[i]), 0);
            check("rst_ov", int'(ovc[i]), 0);
            check("rst_to", int'(toc[i]), 0);
        end
        for (int j = 0; j < 3; j++) tick_cycle(0, 0, 0, 0);

        // Basic pass; dut1 also exercises its watchdog and a spurious done while idle.
        base = cyc; p0 = pub_seen[0];
        for (int t = 0; t < 60; t++) begin
            tick_cycle(0, t == 0, t == 30, t == 40);
            rel = cyc - base;
            if (rel == 1)  check("A_latch0", int'(lat[0]), 1);
            if (rel == 2)  check("A_start0", int'(sta[0]), 1);
            if (rel == 3)  check("A_run0", int'(st[0]), 3);
            if (rel == 31) check("A_wait0", int'(st[0]), 4);
            if (rel == 41) check("A_pub0", int'(pub[0]), 1);
            if (rel == 42) check("A_idle0", int'(st[0]), 0);
            if (rel == 18) check("A_run1_last", int'(st[1]), 3);
            if (rel == 19) check("A_idle1_timeout", int'(st[1]), 0);
        end
        check("A_pubcount0", pub_seen[0] - p0, 1);
        check("A_ov0", int'(ovc[0]), 0);
        check("A_to0", int'(toc[0]), 0);
        check("A_to1", int'(toc[1]), 1);

        // Decimation: only the 1st and 4th windows reach dut1.
        do_reset();
        base = cyc; l0 = lat_seen[1];
        for (int t = 0; t < 200; t++) begin
            tick_cycle(0, (t % 50) == 0, 0, 0);
            rel = cyc - base;
            if (rel == 101) check("B_skip_latch1", int'(lat[1]), 0);
            if (rel == 151) check("B_latch1", int'(lat[1]), 1);
        end
        check("B_latchcount1", lat_seen[1] - l0, 2);
        check("B_ov1", int'(ovc[1]), 0);
        check("B_to1", int'(toc[1]), 2);

        // Overrun saturation while a window waits for its frame tick.
        do_reset();
        base = cyc; p0 = pub_seen[0];
        for (int t = 0; t < 330; t++)
            tick_cycle(0, t == 0 || (t >= 11 && t <= 310), t == 10, t == 320);
        check("C_ov0_sat", int'(ovc[0]), 255);
        check("C_pubcount0", pub_seen[0] - p0, 1);

        // Done and tick together: that tick is not consumed.
        do_reset();
        base = cyc; p0 = pub_seen[0];
        for (int t = 0; t < 50; t++) begin
            tick_cycle(0, t == 0, t == 10 || t == 40, t == 10 || t == 20);
            rel = cyc - base;
            if (rel == 12) check("D_nopub0", int'(pub[0]), 0);
            if (rel == 21) check("D_pub0", int'(pub[0]), 1);
            if (rel == 41) check("D_spurious_done0", int'(st[0]), 0);
        end
        check("D_pubcount0", pub_seen[0] - p0, 1);

        // Reset while waiting for the frame tick aborts without publishing.
        do_reset();
        base = cyc; p0 = pub_seen[0];
        for (int t = 0; t < 40; t++) begin
            tick_cycle(t == 15, t == 0 || t == 5 || t == 20, t == 10, t == 30);
            rel = cyc - base;
            if (rel == 15) check("E_wait0", int'(st[0]), 4);
            if (rel == 16) begin
                check("E_rst_state0", int'(st[0]), 0);
                check("E_rst_ov0", int'(ovc[0]), 0);
                check("E_rst_to1", int'(toc[1]), 0);
            end
            if (rel == 21) check("E_latch0", int'(lat[0]), 1);
            if (rel == 21) check("E_latch1", int'(lat[1]), 1);
        end
        check("E_pubcount0", pub_seen[0] - p0, 0);

        // Random traffic, including occasional resets.
        for (int t = 0; t < 4000; t++)
            tick_cycle($urandom_range(0, 399) == 0, $urandom_range(0, 9) == 0,
                       $urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
